// File: rtl/jt89_pkg.sv
// Shared constants and width helpers for the jt89 mixer family.
package jt89_pkg;

  localparam int GAIN_W  = 4;
  localparam int GAIN_SH = 3;

  // Accumulator width able to hold CH full-scale gained terms without overflow.
  function automatic int sum_w(input int w, input int ch);
    return (ch == 1) ? (w + 1) : (w + 1 + $clog2(ch));
  endfunction

endpackage

// File: rtl/jt89_lpf_stage.sv
// One rounding averaging low-pass stage: y <= (y + x + 1) >> 1 when enabled.
module jt89_lpf_stage #(
  parameter int SW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [SW-1:0] x,
  output logic [SW-1:0] y
);

  logic [SW:0] sum;

  assign sum = {1'b0, y} + {1'b0, x} + (SW+1)'(1);

  always_ff @(posedge clk) begin
    if (rst)
      y <= '0;
    else if (en)
      y <= SW'(sum >> 1);
  end

endmodule

// File: rtl/jt89_multimix.sv
// Time-multiplexed gain/mute channel mixer followed by a cascade of low-pass stages.
module jt89_multimix
  import jt89_pkg::*;
#(
  parameter int CH     = 4,
  parameter int W      = 9,
  parameter int STAGES = 3,
  parameter int OW     = 11,
  parameter int OSH    = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clk_en,
  input  logic [CH*W-1:0]     ch,
  input  logic [CH*GAIN_W-1:0] gain,
  input  logic [CH-1:0]       mute,
  output logic [OW-1:0]       sound,
  output logic                sample_valid,
  output logic                clip
);

  localparam int SW = sum_w(W, CH);
  localparam int IW = (CH > 1) ? $clog2(CH) : 1;
  localparam int CW = (SW > OW) ? SW : OW;
  localparam logic [IW-1:0] LAST = IW'(CH - 1);

  // Returns {clip, saturated value}.
  function automatic logic [OW:0] sat(input logic [SW-1:0] v);
    logic [CW-1:0] ve;
    logic [CW-1:0] mx;
    ve = CW'(v);
    mx = CW'({OW{1'b1}});
    if (ve > mx)
      return {1'b1, {OW{1'b1}}};
    else
      return {1'b0, OW'(ve)};
  endfunction

  logic [IW-1:0]          idx;
  logic [W-1:0]           smp;
  logic [GAIN_W-1:0]      gsel;
  logic                   msel;
  logic [W+GAIN_W-1:0]    prod;
  logic [W:0]             term_p0;
  logic [SW-1:0]          acc_p0;
  logic [SW-1:0]          frame_p1;
  logic                   vld_p1;
  logic                   vld_p2;
  logic [SW-1:0]          s_last;
  logic [SW-1:0]          s_shift;
  logic [OW:0]            sat_res;

  // Stage 0: select the current channel and form its gained term.
  always_comb begin
    smp     = ch[int'(idx)*W +: W];
    gsel    = gain[int'(idx)*GAIN_W +: GAIN_W];
    msel    = mute[idx];
    prod    = {{GAIN_W{1'b0}}, smp} * {{W{1'b0}}, gsel};
    term_p0 = msel ? '0 : (W+1)'(prod >> GAIN_SH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      acc_p0   <= '0;
      frame_p1 <= '0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (clk_en) begin
        if (idx == LAST) begin
          frame_p1 <= acc_p0 + SW'(term_p0);
          acc_p0   <= '0;
          idx      <= '0;
          vld_p1   <= 1'b1;
        end else begin
          acc_p0 <= acc_p0 + SW'(term_p0);
          idx    <= idx + 1'b1;
        end
      end
    end
  end

  // Stage 1: filter cascade, all stages step together from pre-edge values.
  generate
    if (STAGES == 0) begin : g_bypass
      // Hold the frame so back-to-back frames cannot overwrite it before output.
      logic [SW-1:0] byp_p2;
      always_ff @(posedge clk) begin
        if (rst)
          byp_p2 <= '0;
        else if (vld_p1)
          byp_p2 <= frame_p1;
      end
      assign s_last = byp_p2;
    end else begin : g_lpf
      logic [SW-1:0] s_chain [0:STAGES];
      assign s_chain[0] = frame_p1;
      for (genvar k = 0; k < STAGES; k++) begin : g_stage
        jt89_lpf_stage #(.SW(SW)) u_stage (
          .clk (clk),
          .rst (rst),
          .en  (vld_p1),
          .x   (s_chain[k]),
          .y   (s_chain[k+1])
        );
      end
      assign s_last = s_chain[STAGES];
    end
  endgenerate

  assign s_shift = s_last >> OSH;
  assign sat_res = sat(s_shift);

  // Stage 2: scale, saturate and publish.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2       <= 1'b0;
      sample_valid <= 1'b0;
      sound        <= '0;
      clip         <= 1'b0;
    end else begin
      vld_p2       <= vld_p1;
      sample_valid <= vld_p2;
      if (vld_p2) begin
        clip  <= sat_res[OW];
        sound <= sat_res[OW-1:0];
      end
    end
  end

endmodule

// File: tb/tb_jt89_multimix.sv
// Scoreboard bench for jt89_multimix: default build plus an OSH=0 build on shared inputs.
module tb_jt89_multimix;

  localparam int CH = 4;
  localparam int W  = 9;

  logic              clk = 1'b0;
  logic              rst;
  logic              clk_en;
  logic [CH*W-1:0]   ch;
  logic [CH*4-1:0]   gain;
  logic [CH-1:0]     mute;
  logic [10:0]       sound_a, sound_b;
  logic              sv_a, sv_b, clip_a, clip_b;

  jt89_multimix dut_a (
    .clk(clk), .rst(rst), .clk_en(clk_en), .ch(ch), .gain(gain), .mute(mute),
    .sound(sound_a), .sample_valid(sv_a), .clip(clip_a)
  );

  jt89_multimix #(.OSH(0)) dut_b (
    .clk(clk), .rst(rst), .clk_en(clk_en), .ch(ch), .gain(gain), .mute(mute),
    .sound(sound_b), .sample_valid(sv_b), .clip(clip_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int edge_n;
    int snd_a;
    int clp_a;
    int snd_b;
    int clp_b;
  } exp_t;

  exp_t sb[$];
  int   errs = 0;
  int   checks = 0;
  int   nstrobe = 0;
  int   last_strobe = 0;
  bit   mono_chk = 0;
  int   prev_a = 0;

  int   m_idx, m_acc;
  int   m_s[3];
  bit   pend;
  exp_t pend_e;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_idx = 0;
    m_acc = 0;
    for (int k = 0; k < 3; k++) m_s[k] = 0;
  endtask

  function automatic int sat11(input int v);
    return (v > 2047) ? 2047 : v;
  endfunction

  task automatic model_step();
    int term, c, g, frame, n0, n1, n2;
    c = ch[m_idx*W +: W];
    g = gain[m_idx*4 +: 4];
    term = mute[m_idx] ? 0 : (c * g) / 8;
    if (m_idx == CH - 1) begin
      frame = m_acc + term;
      m_acc = 0;
      m_idx = 0;
      n0 = (m_s[0] + frame + 1) / 2;
      n1 = (m_s[1] + m_s[0] + 1) / 2;
      n2 = (m_s[2] + m_s[1] + 1) / 2;
      m_s[0] = n0; m_s[1] = n1; m_s[2] = n2;
      pend_e.snd_a = sat11(n2 / 2);
      pend_e.clp_a = (n2 / 2 > 2047) ? 1 : 0;
      pend_e.snd_b = sat11(n2);
      pend_e.clp_b = (n2 > 2047) ? 1 : 0;
      pend = 1;
    end else begin
      m_acc += term;
      m_idx++;
    end
  endtask

  task automatic tick(input bit en);
    clk_en = en;
    pend = 0;
    if (en && !rst) model_step();
    @(posedge clk);
    #1;
    if (pend) begin
      pend_e.edge_n = cyc;
      sb.push_back(pend_e);
    end
  endtask

  task automatic set_all(input int val, input int g, input logic [CH-1:0] m);
    for (int i = 0; i < CH; i++) begin
      ch[i*W +: W]   = W'(val);
      gain[i*4 +: 4] = 4'(g);
    end
    mute = m;
  endtask

  always @(negedge clk) begin
    if (sv_a) begin
      exp_t e;
      nstrobe++;
      last_strobe = cyc;
      if (sb.size() == 0) begin
        check_val("unexpected_strobe", 1, 0);
      end else begin
        e = sb.pop_front();
        check_val("latency", cyc, e.edge_n + 2);
        check_val("sound_a", sound_a, e.snd_a);
        check_val("clip_a", clip_a, e.clp_a);
        check_val("valid_b", sv_b, 1);
        check_val("sound_b", sound_b, e.snd_b);
        check_val("clip_b", clip_b, e.clp_b);
        if (mono_chk) check_val("monotonic", sound_a >= 11'(prev_a), 1);
      end
      prev_a = sound_a;
    end
  end

  initial begin
    int n0, s0, rel;
    rst = 1'b1;
    clk_en = 1'b0;
    ch = '0;
    mute = '0;
    gain = '0;
    set_all(0, 8, '0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_sound", sound_a, 0);
    check_val("rst_clip", clip_a, 0);
    check_val("rst_valid", sv_a, 0);
    check_val("rst_sound_b", sound_b, 0);
    rst = 1'b0;

    // all-zero input
    repeat (10 * CH) tick(1);
    check_val("zero_sound", sound_a, 0);
    check_val("zero_strobes", nstrobe, 9);

    // muted channel 1, then unmuted
    set_all(0, 8, 4'b0010);
    ch[1*W +: W] = 9'd511;
    repeat (20 * CH) tick(1);
    check_val("muted_zero", sound_a, 0);
    mute = '0;
    repeat (40 * CH) tick(1);
    check_val("unmute_255", sound_a, 255);

    // full-scale unity gain, monotonic rise
    set_all(511, 8, '0);
    prev_a = sound_a;
    mono_chk = 1;
    repeat (40 * CH) tick(1);
    mono_chk = 0;
    check_val("settle_1022", sound_a, 1022);
    check_val("settle_clip", clip_a, 0);

    // freeze mid-frame at idx 2
    tick(1); tick(1);
    repeat (3) tick(0);
    n0 = nstrobe;
    s0 = sound_a;
    repeat (100) tick(0);
    check_val("freeze_nostrobe", nstrobe, n0);
    check_val("freeze_sound", sound_a, s0);
    tick(1); tick(1);
    repeat (3) tick(0);
    check_val("resume_strobe", nstrobe, n0 + 1);

    // maximum gain: OSH=0 build saturates
    set_all(511, 15, '0);
    repeat (40 * CH) tick(1);
    check_val("sat_sound_b", sound_b, 2047);
    check_val("sat_clip_b", clip_b, 1);
    check_val("nosat_sound_a", sound_a, 1916);

    // random channel/gain/mute patterns
    for (int f = 0; f < 20 * CH; f++) begin
      for (int i = 0; i < CH; i++) begin
        ch[i*W +: W]   = W'($urandom_range(0, 511));
        gain[i*4 +: 4] = 4'($urandom_range(0, 15));
      end
      mute = CH'($urandom_range(0, 15));
      tick(1);
    end

    // reset mid-frame at idx 2
    set_all(100, 8, '0);
    repeat (3) tick(0);
    for (int k = 0; k < 8 && m_idx != 2; k++) tick(1);
    check_val("pre_rst_idx", m_idx, 2);
    rst = 1'b1;
    clk_en = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    rel = cyc;
    n0 = nstrobe;
    for (int k = 0; k < 20 && nstrobe == n0; k++) tick(1);
    check_val("post_rst_first", last_strobe, rel + 6);

    repeat (6) tick(0);
    check_val("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
